// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LSB first, start/busy/done handshake.
// Define BCD_CHECK_EN to flag operands containing non-BCD digits (err=1, sum=0, cout=0 for that op).
module bcd_serial_addsub #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, acc, acc_nxt;
  logic            sub_q, carry, c_nxt;
  logic [IW-1:0]   idx;
  logic [3:0]      a_dig, b_dig, bd, digit;
  logic [4:0]      t;
  logic            accept, bad_any;

  assign accept = start && (state != CALC);
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single digit slice; subtraction adds the 9's complement of b with the carry preloaded to ~borrow.
  always_comb begin
    a_dig = a_q[3:0];
    b_dig = b_q[3:0];
    bd    = sub_q ? (4'd9 - b_dig) : b_dig;
    t     = {1'b0, a_dig} + {1'b0, bd} + {4'b0, carry};
    digit = t[3:0];
    c_nxt = 1'b0;
    if (t > 5'd9) begin
      digit = t[3:0] + 4'd6;
      c_nxt = 1'b1;
    end
    acc_nxt = (acc >> 4) | (W'(digit) << (W - 4));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= sub;
      carry <= sub ? ~cin : cin;
      idx   <= '0;
      acc   <= '0;
    end else if (state == CALC) begin
      a_q   <= a_q >> 4;
      b_q   <= b_q >> 4;
      carry <= c_nxt;
      acc   <= acc_nxt;
      idx   <= idx + 1'b1;
      if (idx == LAST) begin
        sum  <= bad_any ? '0 : acc_nxt;
        cout <= c_nxt & ~bad_any;
      end
    end
  end

`ifdef BCD_CHECK_EN
  logic bad_q, err_q;

  // Sticky per-operation flag: any digit above 9 in either operand poisons the result.
  assign bad_any = bad_q | (a_dig > 4'd9) | (b_dig > 4'd9);
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      bad_q <= 1'b0;
    end else if (state == CALC) begin
      bad_q <= bad_any;
      if (idx == LAST) err_q <= bad_any;
    end
  end
`else
  assign bad_any = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub: vector table, hand-written handshake cases and
// randomized operations checked against a decimal-arithmetic reference model.
module tb_bcd_serial_addsub;

  localparam int D = 3;
  localparam int W = 4 * D;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [W-1:0]  a = '0, b = '0, sum;
  logic          busy, done, cout, err;

  logic          start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [15:0]   a4 = '0, b4 = '0, sum4;
  logic          busy4, done4, cout4, err4;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  bcd_serial_addsub #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  bcd_serial_addsub #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .cin(cin4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .err(err4)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         s, c;
    logic [W-1:0] esum;
    logic         ecout, eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic int bcd2int(input logic [31:0] v, input int n);
    int r = 0;
    for (int k = n - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input int v, input int n);
    logic [31:0] r = '0;
    int x = v;
    for (int k = 0; k < n; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: plain decimal arithmetic with 10^n wrap and borrow reported as cout=0.
  function automatic void model(input logic [31:0] av, input logic [31:0] bv, input bit s,
                                input bit c, input int n, output logic [31:0] es, output bit ec);
    int m = 10 ** n;
    int r;
    if (!s) begin
      r  = bcd2int(av, n) + bcd2int(bv, n) + int'(c);
      ec = (r >= m);
      if (ec) r = r - m;
    end else begin
      r  = bcd2int(av, n) - bcd2int(bv, n) - int'(c);
      ec = (r >= 0);
      if (!ec) r = r + m;
    end
    es = int2bcd(r, n);
  endfunction

  function automatic logic [W-1:0] randBcd();
    logic [W-1:0] v;
    for (int k = 0; k < D; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Presents an operation at the negedge, lets E0 sample it, then scrambles the inputs.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               input logic ts, input logic tc);
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run4(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                      input logic tc, output int lat);
    @(negedge clk);
    a4 = ta; b4 = tb_v; sub4 = ts; cin4 = tc; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    a4 = 16'($urandom); b4 = 16'($urandom);
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int dcount;
    logic [31:0] es;
    bit ec;

    tbl.push_back('{a: 12'h999, b: 12'h001, s: 1'b0, c: 1'b0, esum: 12'h000, ecout: 1'b1, eerr: 1'b0});
    tbl.push_back('{a: 12'h045, b: 12'h055, s: 1'b0, c: 1'b1, esum: 12'h101, ecout: 1'b0, eerr: 1'b0});
    tbl.push_back('{a: 12'h500, b: 12'h123, s: 1'b1, c: 1'b0, esum: 12'h377, ecout: 1'b1, eerr: 1'b0});
    tbl.push_back('{a: 12'h123, b: 12'h500, s: 1'b1, c: 1'b0, esum: 12'h623, ecout: 1'b0, eerr: 1'b0});
    tbl.push_back('{a: 12'h000, b: 12'h000, s: 1'b1, c: 1'b1, esum: 12'h999, ecout: 1'b0, eerr: 1'b0});
    tbl.push_back('{a: 12'h999, b: 12'h999, s: 1'b0, c: 1'b1, esum: 12'h999, ecout: 1'b1, eerr: 1'b0});
    tbl.push_back('{a: 12'h999, b: 12'h999, s: 1'b1, c: 1'b0, esum: 12'h000, ecout: 1'b1, eerr: 1'b0});
`ifdef BCD_CHECK_EN
    tbl.push_back('{a: 12'h0A3, b: 12'h001, s: 1'b0, c: 1'b0, esum: 12'h000, ecout: 1'b0, eerr: 1'b1});
    tbl.push_back('{a: 12'h123, b: 12'h456, s: 1'b0, c: 1'b0, esum: 12'h579, ecout: 1'b0, eerr: 1'b0});
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outputs", {27'b0, busy, done, cout, err, |sum}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c);
      waitDone(lat);
      checkOutput($sformatf("vec%0d latency", i), lat, D);
      checkOutput($sformatf("vec%0d busy", i), busy, 1'b0);
      checkOutput($sformatf("vec%0d sum", i), sum, tbl[i].esum);
      checkOutput($sformatf("vec%0d cout", i), cout, tbl[i].ecout);
      checkOutput($sformatf("vec%0d err", i), err, tbl[i].eerr);
    end

    // Extra start pulse one cycle into CALC must not restart or alter the operation.
    applyStimulus(12'h500, 12'h123, 1'b1, 1'b0);
    @(negedge clk);
    a = 12'h999; b = 12'h001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(lat);
    checkOutput("ignored start latency", lat + 1, D);
    checkOutput("ignored start sum", sum, 12'h377);
    checkOutput("ignored start cout", cout, 1'b1);

    // Back-to-back start in the DONE cycle; previous result stays visible during CALC.
    applyStimulus(12'h045, 12'h055, 1'b0, 1'b1);
    checkOutput("b2b busy", busy, 1'b1);
    checkOutput("b2b sum held", sum, 12'h377);
    waitDone(lat);
    checkOutput("b2b latency", lat, D);
    checkOutput("b2b sum", sum, 12'h101);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      bit rs, rc;
      ra = randBcd();
      rb = randBcd();
      rs = 1'($urandom);
      rc = 1'($urandom);
      model(32'(ra), 32'(rb), rs, rc, D, es, ec);
      applyStimulus(ra, rb, rs, rc);
      waitDone(lat);
      checkOutput($sformatf("rand%0d latency", i), lat, D);
      checkOutput($sformatf("rand%0d sum", i), sum, es[W-1:0]);
      checkOutput($sformatf("rand%0d cout", i), cout, ec);
      checkOutput($sformatf("rand%0d err", i), err, 1'b0);
    end

    // Reset asserted mid-CALC aborts the operation with no done pulse.
    applyStimulus(12'h123, 12'h456, 1'b0, 1'b0);
    waitDone(lat);
    checkOutput("pre-abort sum", sum, 12'h579);
    applyStimulus(12'h111, 12'h222, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort outputs", {27'b0, busy, done, cout, err, |sum}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    checkOutput("abort no done", dcount, 0);
    applyStimulus(12'h250, 12'h250, 1'b0, 1'b0);
    waitDone(lat);
    checkOutput("post-abort latency", lat, D);
    checkOutput("post-abort sum", sum, 12'h500);

    run4(16'h9999, 16'h0001, 1'b0, 1'b0, lat);
    checkOutput("d4 latency", lat, 4);
    checkOutput("d4 sum", sum4, 16'h0000);
    checkOutput("d4 cout", cout4, 1'b1);
    for (int i = 0; i < 10; i++) begin
      logic [15:0] ra, rb;
      bit rs, rc;
      for (int k = 0; k < 4; k++) begin
        ra[4*k +: 4] = 4'($urandom_range(0, 9));
        rb[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      rs = 1'($urandom);
      rc = 1'($urandom);
      model(32'(ra), 32'(rb), rs, rc, 4, es, ec);
      run4(ra, rb, rs, rc, lat);
      checkOutput($sformatf("d4 rand%0d latency", i), lat, 4);
      checkOutput($sformatf("d4 rand%0d sum", i), sum4, es[15:0]);
      checkOutput($sformatf("d4 rand%0d cout", i), cout4, ec);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
